// File: rtl/sobel_window_ctrl.sv
// Stream-position controller for the Sobel window datapath. It drives the shared
// advance strobe, tracks the pixel position in the frame, and registers the frame/window flags.
module sobel_window_ctrl #(
    parameter int COLS_P   = 640,
    parameter int ROWS_P   = 480,
    parameter int KERNEL_P = 3
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clear_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        advance_o,
    output logic [$clog2(COLS_P)-1:0]   col_o,
    output logic [$clog2(ROWS_P)-1:0]   row_o,
    output logic                        win_valid_o,
    output logic                        sof_o,
    output logic                        eol_o,
    output logic                        eof_o,
    output logic [1:0]                  state_o,
    output logic                        frame_done_o
);

    localparam int COL_W = $clog2(COLS_P);
    localparam int ROW_W = $clog2(ROWS_P);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_P - 1);
    localparam logic [ROW_W-1:0] ROW_FILL = ROW_W'(KERNEL_P - 2);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KERNEL_P - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KERNEL_P - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [ROW_W-1:0]  row_reg, row_next;

    logic              valid_reg, valid_next;
    logic [COL_W-1:0]  col_out_reg, col_out_next;
    logic [ROW_W-1:0]  row_out_reg, row_out_next;
    logic              win_reg, win_next;
    logic              sof_reg, sof_next;
    logic              eol_reg, eol_next;
    logic              eof_reg, eof_next;
    logic              frame_done_reg, frame_done_next;

    logic              col_last, row_last;
    logic              sof_now, eol_now, eof_now, win_now;

    // Clear blocks the upstream handshake so no pixel is consumed while aborting.
    assign ready_o   = ~clear_i & (ready_i | ~valid_reg);
    assign advance_o = valid_i & ready_o;

    assign col_last = (col_reg == COL_LAST);
    assign row_last = (row_reg == ROW_LAST);
    assign sof_now  = (col_reg == '0) & (row_reg == '0);
    assign eol_now  = col_last;
    assign eof_now  = col_last & row_last;
    assign win_now  = (row_reg >= ROW_WIN) & (col_reg >= COL_WIN);

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        if (clear_i) begin
            state_next = ST_IDLE;
            col_next   = '0;
            row_next   = '0;
        end else if (advance_o) begin
            col_next = col_last ? '0 : col_reg + COL_W'(1);
            if (col_last) begin
                row_next = row_last ? '0 : row_reg + ROW_W'(1);
            end
            case (state_reg)
                ST_IDLE: state_next = ST_FILL;
                ST_FILL: if (col_last && (row_reg == ROW_FILL)) state_next = ST_RUN;
                ST_RUN:  if (eof_now) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Single output stage: a new accept overwrites a draining pixel with no bubble.
    always_comb begin
        valid_next      = valid_reg;
        col_out_next    = col_out_reg;
        row_out_next    = row_out_reg;
        win_next        = win_reg;
        sof_next        = sof_reg;
        eol_next        = eol_reg;
        eof_next        = eof_reg;
        frame_done_next = advance_o & eof_now;
        if (clear_i) begin
            valid_next   = 1'b0;
            col_out_next = '0;
            row_out_next = '0;
            win_next     = 1'b0;
            sof_next     = 1'b0;
            eol_next     = 1'b0;
            eof_next     = 1'b0;
        end else if (advance_o) begin
            valid_next   = 1'b1;
            col_out_next = col_reg;
            row_out_next = row_reg;
            win_next     = win_now;
            sof_next     = sof_now;
            eol_next     = eol_now;
            eof_next     = eof_now;
        end else if (ready_i) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg      <= ST_IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            valid_reg      <= 1'b0;
            col_out_reg    <= '0;
            row_out_reg    <= '0;
            win_reg        <= 1'b0;
            sof_reg        <= 1'b0;
            eol_reg        <= 1'b0;
            eof_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            valid_reg      <= valid_next;
            col_out_reg    <= col_out_next;
            row_out_reg    <= row_out_next;
            win_reg        <= win_next;
            sof_reg        <= sof_next;
            eol_reg        <= eol_next;
            eof_reg        <= eof_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign valid_o      = valid_reg;
    assign col_o        = col_out_reg;
    assign row_o        = row_out_reg;
    assign win_valid_o  = win_reg;
    assign sof_o        = sof_reg;
    assign eol_o        = eol_reg;
    assign eof_o        = eof_reg;
    assign state_o      = state_reg;
    assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x3 frame with a 3x3 kernel; accepted
// pixels are queued as expected records and popped as the output stage drains.
module tb_sobel_window_ctrl;

    localparam int C = 4;
    localparam int R = 3;
    localparam int K = 3;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       ready_o, valid_o, advance_o;
    logic [1:0] col_o, row_o, state_o;
    logic       win_valid_o, sof_o, eol_o, eof_o, frame_done_o;

    sobel_window_ctrl #(.COLS_P(C), .ROWS_P(R), .KERNEL_P(K)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .advance_o    (advance_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .win_valid_o  (win_valid_o),
        .sof_o        (sof_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o),
        .state_o      (state_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int col;
        int row;
        bit sof;
        bit eol;
        bit eof;
        bit win;
    } pix_t;

    pix_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_col = 0, m_row = 0, m_state = 0;
    bit   m_valid = 0, m_fd = 0;
    int   n_valid, n_win, n_eol, n_eof, n_sof, n_fd, n_xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_win = 0; n_eol = 0; n_eof = 0; n_sof = 0; n_fd = 0; n_xfer = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 0; m_fd = 0; m_col = 0; m_row = 0; m_state = 0;
    endtask

    // One clock: drive inputs, check handshake, advance the model, check registered outputs.
    task automatic cycle(input logic v, input logic rdy, input logic clr);
        logic exp_rdy, exp_adv, cons;
        pix_t p;
        valid_i = v; ready_i = rdy; clear_i = clr;
        #1;
        exp_rdy = !clr && (rdy || !m_valid);
        exp_adv = v && exp_rdy;
        check("ready_o", ready_o, exp_rdy);
        check("advance_o", advance_o, exp_adv);
        if (valid_o && rdy && !clr) n_xfer++;
        cons = m_valid && rdy && !clr;
        m_fd = 0;
        if (clr) begin
            model_reset();
        end else begin
            if (cons) void'(q.pop_front());
            if (exp_adv) begin
                p.col = m_col;
                p.row = m_row;
                p.sof = (m_col == 0) && (m_row == 0);
                p.eol = (m_col == C - 1);
                p.eof = p.eol && (m_row == R - 1);
                p.win = (m_row >= K - 1) && (m_col >= K - 1);
                q.push_back(p);
                m_valid = 1;
                m_fd = p.eof;
                case (m_state)
                    0: m_state = 1;
                    1: if (m_row == K - 2 && m_col == C - 1) m_state = 2;
                    default: if (p.eof) m_state = 0;
                endcase
                if (m_col == C - 1) begin
                    m_col = 0;
                    m_row = (m_row == R - 1) ? 0 : m_row + 1;
                end else begin
                    m_col = m_col + 1;
                end
            end else if (rdy) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check("valid_o", valid_o, m_valid);
        check("frame_done_o", frame_done_o, m_fd);
        check("state_o", state_o, m_state);
        if (m_valid && q.size() > 0) begin
            p = q[0];
            check("col_o", col_o, p.col);
            check("row_o", row_o, p.row);
            check("sof_o", sof_o, p.sof);
            check("eol_o", eol_o, p.eol);
            check("eof_o", eof_o, p.eof);
            check("win_valid_o", win_valid_o, p.win);
        end
        if (valid_o) begin
            n_valid++;
            if (win_valid_o) n_win++;
            if (eol_o) n_eol++;
            if (eof_o) n_eof++;
            if (sof_o) n_sof++;
            $display("out col=%0d row=%0d sof=%0b eol=%0b eof=%0b win=%0b state=%0d",
                     col_o, row_o, sof_o, eol_o, eof_o, win_valid_o, state_o);
        end
        if (frame_done_o) n_fd++;
    endtask

    initial begin
        logic [1:0] hold_col, hold_row;

        // Reset state
        #2;
        check("rst valid_o", valid_o, 0);
        check("rst col_o", col_o, 0);
        check("rst row_o", row_o, 0);
        check("rst sof_o", sof_o, 0);
        check("rst eol_o", eol_o, 0);
        check("rst eof_o", eof_o, 0);
        check("rst win_valid_o", win_valid_o, 0);
        check("rst state_o", state_o, 0);
        check("rst frame_done_o", frame_done_o, 0);
        check("rst ready_o", ready_o, 1);
        #4;
        rstn_i = 1'b1;

        // 1: one full frame back to back
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0);
            if (i == 0)  check("t1 state after px0", state_o, 1);
            if (i == 7)  check("t1 state after px7", state_o, 2);
            if (i == 11) check("t1 state after px11", state_o, 0);
        end
        cycle(0, 1, 0);
        check("t1 valid cycles", n_valid, 12);
        check("t1 win count", n_win, 2);
        check("t1 eol count", n_eol, 3);
        check("t1 eof count", n_eof, 1);
        check("t1 sof count", n_sof, 1);
        check("t1 frame_done pulses", n_fd, 1);

        // 2: downstream stall mid-line
        clear_stats();
        for (int i = 0; i < 5; i++) cycle(1, 1, 0);
        hold_col = col_o;
        hold_row = row_o;
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0);
            check("t2 col held", col_o, hold_col);
            check("t2 row held", row_o, hold_row);
        end
        for (int i = 0; i < 7; i++) cycle(1, 1, 0);
        cycle(0, 1, 0);
        check("t2 transfers", n_xfer, 12);
        check("t2 frame_done pulses", n_fd, 1);

        // 3: upstream bubbles
        clear_stats();
        for (int i = 0; i < 24; i++) cycle((i % 2) == 0, 1, 0);
        cycle(0, 1, 0);
        check("t3 transfers", n_xfer, 12);
        check("t3 valid cycles", n_valid, 12);

        // 4: two frames with no gap
        clear_stats();
        for (int i = 0; i < 24; i++) begin
            cycle(1, 1, 0);
            if (i == 11) check("t4 state end f1", state_o, 0);
            if (i == 12) begin
                check("t4 state start f2", state_o, 1);
                check("t4 sof f2", sof_o, 1);
            end
            if (i == 19) check("t4 state run f2", state_o, 2);
        end
        cycle(0, 1, 0);
        check("t4 frame_done pulses", n_fd, 2);
        check("t4 sof count", n_sof, 2);

        // 5: clear at pixel 6
        clear_stats();
        for (int i = 0; i < 6; i++) cycle(1, 1, 0);
        cycle(1, 1, 1);
        check("t5 state after clear", state_o, 0);
        check("t5 valid after clear", valid_o, 0);
        cycle(1, 1, 0);
        check("t5 restart col", col_o, 0);
        check("t5 restart row", row_o, 0);
        check("t5 restart sof", sof_o, 1);
        for (int i = 0; i < 11; i++) cycle(1, 1, 0);
        cycle(0, 1, 0);
        check("t5 frame_done pulses", n_fd, 1);

        // 6: asynchronous reset between edges
        clear_stats();
        for (int i = 0; i < 5; i++) cycle(1, 1, 0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        #3;
        rstn_i = 1'b0;
        #1;
        check("t6 valid_o", valid_o, 0);
        check("t6 col_o", col_o, 0);
        check("t6 row_o", row_o, 0);
        check("t6 sof_o", sof_o, 0);
        check("t6 eol_o", eol_o, 0);
        check("t6 eof_o", eof_o, 0);
        check("t6 win_valid_o", win_valid_o, 0);
        check("t6 state_o", state_o, 0);
        check("t6 frame_done_o", frame_done_o, 0);
        model_reset();
        #2;
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 1, 0);
        check("t6 restart col", col_o, 0);
        check("t6 restart row", row_o, 0);
        check("t6 restart sof", sof_o, 1);
        for (int i = 0; i < 11; i++) cycle(1, 1, 0);
        cycle(0, 1, 0);
        check("t6 frame_done pulses", n_fd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Stream-position controller for the Sobel line-buffer/window datapath. Accepts the raw pixel valid/ready stream and produces the common advance strobe for the delay buffers. Tracks column and row position within a frame and flags which outputs form a complete KERNEL_P x KERNEL_P window. It also emits frame/line markers and sequences fill, run and frame-end through a small FSM. It carries no pixel data; the datapath taps `advance_o` and the registered position/flag outputs.

Parameters:
- COLS_P, 640, pixels per line (>= KERNEL_P)
- ROWS_P, 480, lines per frame (>= KERNEL_P)
- KERNEL_P, 3, window size; rows/cols of history before a window is valid (>= 2)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort; restart frame
- valid_i  in  1  upstream pixel valid
- ready_o  out  1  upstream ready
- valid_o  out  1  downstream valid (position/flags below qualified by it)
- ready_i  in  1  downstream ready
- advance_o  out  1  combinational valid_i & ready_o; drives buffer write/read enables
- col_o  out  $clog2(COLS_P)  column of the accepted pixel
- row_o  out  $clog2(ROWS_P)  row of the accepted pixel
- win_valid_o  out  1  window centred one pixel up-left is complete
- sof_o  out  1  first pixel of frame
- eol_o  out  1  last pixel of line
- eof_o  out  1  last pixel of frame
- state_o  out  2  FSM state (0 IDLE, 1 FILL, 2 RUN)
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async, rstn_i low): valid_o, win_valid_o, sof_o, eol_o, eof_o and frame_done_o are 0; col_o and row_o are 0; internal col/row counters are 0; state is IDLE.
- Handshake:
  - Single output register stage: ready_o = ready_i | ~valid_o.
  - Accept = valid_i & ready_o = advance_o.
  - On accept, the output register loads the current counter position and flags, and valid_o is set on the next edge.
  - If no accept and ready_i is high, valid_o clears.
  - If valid_o is high and ready_i is low, all outputs hold stable.
  - Latency is 1 cycle.
  - Full throughput: one pixel per cycle when ready_i stays high.
- Counters (advance only on accept):
  - col increments and wraps COLS_P-1 -> 0.
  - On that wrap, row increments and wraps ROWS_P-1 -> 0.
  - There are no other wrap points.
- Flags (computed from pre-increment counters, registered with the pixel):
  - sof = (col==0 & row==0)
  - eol = (col==COLS_P-1)
  - eof = eol & (row==ROWS_P-1)
  - win_valid = (row >= KERNEL_P-1) & (col >= KERNEL_P-1)
- FSM:
  - IDLE -> FILL on any accept.
  - FILL -> RUN on accepting pixel (row=KERNEL_P-2, col=COLS_P-1).
  - RUN -> IDLE on accepting the eof pixel; the counters have wrapped to 0 at that point.
  - A frame is entered directly in FILL from its first pixel, so sof coincides with the IDLE->FILL transition.
- frame_done_o: registered pulse, high for exactly one cycle on the edge after the eof accept, independent of ready_i.
- clear_i (synchronous, highest priority over accept):
  - next state IDLE; counters 0.
  - valid_o, win_valid_o and flags drop to 0; frame_done_o 0.
  - ready_o during clear_i is forced to 0, so advance_o=0 and no pixel is consumed.
- Simultaneous accept and output drain: the new pixel replaces the old one in the same cycle with no bubble.
- Reset or clear mid-frame: the next accepted pixel is treated as (0,0) with sof=1. Stale line-buffer contents are masked by win_valid=0 until KERNEL_P-1 rows are refilled.

Test Plan:
1. COLS_P=4, ROWS_P=3, KERNEL_P=3; 12 back-to-back pixels, ready_i=1:
   - valid_o for 12 cycles starting 1 cycle after the first accept.
   - sof on pixel 0; eol on pixels 3, 7, 11; eof on pixel 11.
   - win_valid only on (2,2) and (2,3).
   - state FILL after pixel 0, RUN after pixel 7, IDLE after pixel 11.
   - frame_done_o pulses once.
2. Backpressure: ready_i=0 for 5 cycles mid-line:
   - ready_o=0 and advance_o=0 while valid_o is held.
   - col_o/row_o stable.
   - No pixel is lost or duplicated; the column sequence stays contiguous.
3. Bubbles: valid_i toggling 1,0,1,0:
   - Counters advance only on accepts.
   - valid_o low in gap cycles.
4. Two consecutive frames with no gap:
   - The second frame starts with sof=1 at (0,0).
   - FSM goes RUN -> IDLE -> FILL.
   - frame_done_o is one pulse per frame.
5. clear_i asserted at pixel 6 with valid_i=1:
   - That pixel is not accepted; state IDLE; valid_o=0 next cycle.
   - The next accept reports (0,0) with sof=1.
6. rstn_i asserted asynchronously mid-frame between clock edges:
   - All outputs go to 0 immediately.
   - After release, the frame restarts from (0,0).
